// File: rtl/sd_seq_mon_if.sv
// Stream channel into the sequence monitor: srdy/drdy handshake plus data word.
interface sd_seq_mon_if #(
  parameter int width = 16
) ();
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;

  // Producer side drives valid and data and observes ready.
  modport master (output c_srdy, output c_data, input c_drdy);
  // Monitor side observes valid and data and drives ready.
  modport slave  (input c_srdy, input c_data, output c_drdy);
endinterface

// File: rtl/sd_seq_mon.sv
// Stream sequence monitor: throttles its upstream with a rotating ready
// pattern, checks accepted words form a +1 sequence and keeps saturating
// transfer/error statistics.
module sd_seq_mon #(
  parameter int width      = 16,
  parameter int cnt_width  = 16,
  parameter bit sync_first = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  sd_seq_mon_if.slave          c,
  input  logic [7:0]           drdy_pat,
  input  logic                 clear,
  output logic                 err_flag,
  output logic [cnt_width-1:0] err_count,
  output logic [cnt_width-1:0] xfer_count,
  output logic [width-1:0]     last_seq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_e;

  localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);
  localparam logic [width-1:0]     data_one = width'(1);

  state_e               state_q, state_d;
  logic [2:0]           pat_ptr_q;
  logic                 drdy_q;
  logic [width-1:0]     exp_q, exp_d;
  logic [width-1:0]     last_q, last_d;
  logic [cnt_width-1:0] err_cnt_q, err_cnt_d;
  logic [cnt_width-1:0] xfer_cnt_q, xfer_cnt_d;

  logic xfer;
  logic compare;
  logic mismatch;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + cnt_one;
  endfunction

  // Ready comes only from a register, so it never depends on c_srdy/c_data.
  assign xfer     = c.c_srdy & drdy_q;
  // The first word after reset/clear only seeds the expectation when sync_first is set.
  assign compare  = !((state_q == IDLE) && sync_first);
  assign mismatch = compare && (c.c_data != exp_q);

  // Free-running pattern pointer and registered ready; clear leaves it alone.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_ptr_q <= 3'd0;
      drdy_q    <= 1'b0;
    end else begin
      pat_ptr_q <= pat_ptr_q + 3'd1;
      drdy_q    <= drdy_pat[pat_ptr_q];
    end
  end

  // Statistics next-state: clear wins over a coincident transfer.
  // NOTE: every output of this block is defaulted first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    exp_d      = exp_q;
    last_d     = last_q;
    err_cnt_d  = err_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    if (clear) begin
      exp_d      = '0;
      last_d     = '0;
      err_cnt_d  = '0;
      xfer_cnt_d = '0;
    end else if (xfer) begin
      last_d     = c.c_data;
      xfer_cnt_d = sat_inc(xfer_cnt_q);
      // On a match c_data equals exp, so c_data+1 covers both the normal
      // advance and the resync after a discontinuity.
      exp_d      = c.c_data + data_one;
      if (mismatch) begin
        err_cnt_d = sat_inc(err_cnt_q);
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q      <= '0;
      last_q     <= '0;
      err_cnt_q  <= '0;
      xfer_cnt_q <= '0;
    end else begin
      exp_q      <= exp_d;
      last_q     <= last_d;
      err_cnt_q  <= err_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Sequence state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequence next-state: ERR is absorbing until clear or reset.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (xfer) begin
      case (state_q)
        IDLE:    state_d = mismatch ? ERR : RUN;
        RUN:     state_d = mismatch ? ERR : RUN;
        ERR:     state_d = ERR;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sequence outputs: the sticky error flag is simply "in ERR".
  always_comb begin
    err_flag = (state_q == ERR);
  end

  assign c.c_drdy   = drdy_q;
  assign err_count  = err_cnt_q;
  assign xfer_count = xfer_cnt_q;
  assign last_seq   = last_q;

endmodule
